// File: rtl/seq_mul.sv
// Iterative shift-add multiplier: WIDTH-bit operands, 2*WIDTH-bit product after WIDTH RUN cycles.
// Define SEQ_MUL_SIGNED_EN for two's-complement operands (sign-magnitude iteration); default is unsigned.
module seq_mul #(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] OUT,
   output logic [WIDTH-1:0] OUT_HI,
   output logic             OVF,
   output logic             BUSY,
   output logic             VALID
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;    // {partial, multiplier}; carry lives in sum
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic [WIDTH-1:0]   out_hi_q, out_hi_d;
   logic               ovf_q, ovf_d;
   logic               busy_q, busy_d;
   logic               valid_q, valid_d;
`ifdef SEQ_MUL_SIGNED_EN
   logic               sign_q, sign_d;
`endif

   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] fin;
   logic [WIDTH-1:0]   a_cap, b_cap;

   always_comb begin
      // NOTE: every variable gets a default first so no path can leave it unassigned and infer a latch.
      state_d  = state_q;
      mcand_d  = mcand_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      out_d    = out_q;
      out_hi_d = out_hi_q;
      ovf_d    = ovf_q;
      busy_d   = busy_q;
      valid_d  = 1'b0;
      fin      = '0;
`ifdef SEQ_MUL_SIGNED_EN
      sign_d   = sign_q;
      a_cap    = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
      b_cap    = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;
`else
      a_cap    = A;
      b_cap    = B;
`endif
      // (WIDTH+1)-bit add keeps the carry that the right shift pulls into the top bit
      sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);

      case (state_q)
         S_IDLE: begin
            if (START) begin
               state_d = S_RUN;
               mcand_d = a_cap;
               prod_d  = {{WIDTH{1'b0}}, b_cap};
               cnt_d   = '0;
               busy_d  = 1'b1;
`ifdef SEQ_MUL_SIGNED_EN
               sign_d  = A[WIDTH-1] ^ B[WIDTH-1];
`endif
            end
         end
         S_RUN: begin
            prod_d = {sum, prod_q[WIDTH-1:1]};
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH-1)) begin
               state_d = S_DONE;
               valid_d = 1'b1;
`ifdef SEQ_MUL_SIGNED_EN
               fin      = sign_q ? (~prod_d + (2*WIDTH)'(1)) : prod_d;
               out_d    = fin[WIDTH-1:0];
               out_hi_d = fin[2*WIDTH-1:WIDTH];
               ovf_d    = (fin[2*WIDTH-1:WIDTH] != {WIDTH{fin[WIDTH-1]}});
`else
               fin      = prod_d;
               out_d    = fin[WIDTH-1:0];
               out_hi_d = fin[2*WIDTH-1:WIDTH];
               ovf_d    = (fin[2*WIDTH-1:WIDTH] != '0);
`endif
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= S_IDLE;
         mcand_q  <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         out_q    <= '0;
         out_hi_q <= '0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
         sign_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
         out_q    <= out_d;
         out_hi_q <= out_hi_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
`ifdef SEQ_MUL_SIGNED_EN
         sign_q   <= sign_d;
`endif
      end
   end

   assign OUT    = out_q;
   assign OUT_HI = out_hi_q;
   assign OVF    = ovf_q;
   assign BUSY   = busy_q;
   assign VALID  = valid_q;

endmodule
